// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the I/D syncram arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CMD  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Grant, command and response: one access every NUM_PHASES cycles at best.
  localparam int NUM_PHASES = 3;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: round-robin, or D priority with a bounded
// number of consecutive I losses.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIO = 0,
  parameter int MAX_STALL = 3
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic       last_winner,
  input  logic [3:0] stall_cnt,
  output logic       grant_valid,
  output logic       winner
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_valid = i_req | d_req;
    winner      = PORT_I;
    if (DATA_PRIO != 0) begin
      if (d_req && !(i_req && (stall_cnt == 4'(MAX_STALL)))) winner = PORT_D;
    end else if (i_req && d_req) begin
      winner = ~last_winner;
    end else if (d_req) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port syncram between instruction fetch (I) and load/store
// (D) using a fixed grant -> command -> response sequence per access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIO   = 0,
  parameter int MAX_STALL   = 3,
  parameter int INIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        ram_cs,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  logic [1:0] state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;
  logic       last_winner_q, last_winner_d;
  txn_t       txn_q, txn_d;
  logic       grant_valid;
  logic       winner;
  logic       grant;

  mem_arb_pick #(
    .DATA_PRIO(DATA_PRIO),
    .MAX_STALL(MAX_STALL)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_winner(last_winner_q),
    .stall_cnt  (stall_cnt_q),
    .grant_valid(grant_valid),
    .winner     (winner)
  );

  assign grant = (state_q == ST_IDLE) && grant_valid;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    last_winner_d = last_winner_q;
    txn_d         = txn_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == 4'(INIT_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      ST_IDLE: begin
        // I losing while requesting is the only way the stall count grows.
        if (!i_req || (grant && (winner == PORT_I))) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q != 4'(MAX_STALL)) begin
          stall_cnt_d = stall_cnt_q + 4'd1;
        end
        if (grant) begin
          last_winner_d = winner;
          txn_d.owner   = winner;
          txn_d.we      = (winner == PORT_D) && d_we;
          txn_d.addr    = (winner == PORT_D) ? d_addr : i_addr;
          txn_d.wdata   = d_wdata;
          state_d       = ST_CMD;
        end
      end
      ST_CMD:  state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      last_winner_q <= PORT_I;
      txn_q         <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      last_winner_q <= last_winner_d;
      txn_q         <= txn_d;
    end
  end

  assign i_gnt    = grant && (winner == PORT_I);
  assign d_gnt    = grant && (winner == PORT_D);

  assign ram_cs   = (state_q == ST_CMD);
  assign ram_oe   = ram_cs && !txn_q.we;
  assign ram_we   = ram_cs && txn_q.we;
  assign ram_addr = ram_cs ? txn_q.addr : '0;
  assign ram_din  = ram_we ? txn_q.wdata : '0;

  // The memory registers its read data on the command edge, so it is simply
  // steered to the owner during the response cycle.
  assign i_done   = (state_q == ST_RESP) && (txn_q.owner == PORT_I);
  assign d_done   = (state_q == ST_RESP) && (txn_q.owner == PORT_D);
  assign i_rdata  = i_done ? ram_dout : '0;
  assign d_rdata  = (d_done && !txn_q.we) ? ram_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a bounded-priority instance, each with
// a syncram stub, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int INIT_CYCLES = 2;
  localparam int MAX_STALL   = 3;

  logic        clk;
  logic        rst_n;
  logic        i_req [2];
  logic        d_req [2];
  logic        d_we [2];
  logic        i_gnt [2];
  logic        i_done [2];
  logic        d_gnt [2];
  logic        d_done [2];
  logic        ram_cs [2];
  logic        ram_oe [2];
  logic        ram_we [2];
  logic [31:0] i_addr [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [31:0] i_rdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] ram_addr [2];
  logic [31:0] ram_din [2];
  logic [31:0] ram_dout [2];

  for (genvar k = 0; k < 2; k++) begin : g_inst
    mem_arbiter #(
      .DATA_PRIO  (k),
      .MAX_STALL  (MAX_STALL),
      .INIT_CYCLES(INIT_CYCLES)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (i_req[k]),
      .i_addr  (i_addr[k]),
      .i_gnt   (i_gnt[k]),
      .i_done  (i_done[k]),
      .i_rdata (i_rdata[k]),
      .d_req   (d_req[k]),
      .d_we    (d_we[k]),
      .d_addr  (d_addr[k]),
      .d_wdata (d_wdata[k]),
      .d_gnt   (d_gnt[k]),
      .d_done  (d_done[k]),
      .d_rdata (d_rdata[k]),
      .ram_cs  (ram_cs[k]),
      .ram_oe  (ram_oe[k]),
      .ram_we  (ram_we[k]),
      .ram_addr(ram_addr[k]),
      .ram_din (ram_din[k]),
      .ram_dout(ram_dout[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Syncram stub contents and the model's own view of memory.
  logic [31:0] mem [2][64];
  logic [31:0] m_shadow [2][64];

  // Model state per instance: cycles since reset release, earliest next grant,
  // arbitration history and the one outstanding transaction.
  int          m_e [2];
  int          m_free [2];
  int          m_t0 [2];
  int          m_stall [2];
  logic        m_busy [2];
  logic        m_lw [2];
  logic        m_own [2];
  logic        m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [31:0] m_rd [2];
  logic        m_gi [2];
  logic        m_gd [2];

  int exp_order [2][8] = '{'{1, 0, 1, 0, 1, 0, 1, 0}, '{1, 1, 1, 0, 1, 1, 1, 0}};
  int g_port [2][8];
  int g_cyc [2][8];
  int g_n [2];

  function automatic logic [31:0] preload(int i);
    if (i == 1) return 32'h8C22_0000;
    return 32'h5A00_0000 + (i * 32'h0001_0203);
  endfunction

  function automatic logic [159:0] pack(logic gi, logic gd, logic di, logic dd, logic cs,
                                        logic oe, logic we, logic [31:0] ir, logic [31:0] dr,
                                        logic [31:0] ad, logic [31:0] dn);
    return {25'd0, gi, gd, di, dd, cs, oe, we, ir, dr, ad, dn};
  endfunction

  function automatic logic [159:0] dut_vec(int k);
    return pack(i_gnt[k], d_gnt[k], i_done[k], d_done[k], ram_cs[k], ram_oe[k], ram_we[k],
                i_rdata[k], d_rdata[k], ram_addr[k], ram_din[k]);
  endfunction

  task automatic check_vec(string name, logic [159:0] act, logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    check_vec(name, {159'd0, act}, {159'd0, exp});
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    check_vec(name, {128'd0, act}, {128'd0, exp});
  endtask

  // Memory registers read data on the command edge; writes land on that edge too.
  task automatic mem_loop();
    logic [31:0] nxt [2];
    logic        upd [2];
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        upd[k] = 1'b0;
        nxt[k] = '0;
        if (ram_cs[k]) begin
          if (ram_we[k]) mem[k][ram_addr[k][7:2]] = ram_din[k];
          if (ram_oe[k]) begin
            upd[k] = 1'b1;
            nxt[k] = mem[k][ram_addr[k][7:2]];
          end
        end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) if (upd[k]) ram_dout[k] = nxt[k];
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic        gi, gd, di, dd, cs, oe, we, win;
        logic [31:0] ir, dr, ad, dn;
        logic [159:0] act;
        {gi, gd, di, dd, cs, oe, we, win} = '0;
        {ir, dr, ad, dn} = '0;
        act = dut_vec(k);
        if (!rst_n) begin
          m_e[k]     = 0;
          m_free[k]  = INIT_CYCLES;
          m_lw[k]    = PORT_I;
          m_stall[k] = 0;
          m_busy[k]  = 1'b0;
        end else begin
          if (m_busy[k] && (m_e[k] == m_t0[k] + 1)) begin
            cs = 1'b1;
            oe = !m_we[k];
            we = m_we[k];
            ad = m_addr[k];
            dn = m_we[k] ? m_wd[k] : 32'd0;
            if (m_we[k]) m_shadow[k][m_addr[k][7:2]] = m_wd[k];
            else         m_rd[k] = m_shadow[k][m_addr[k][7:2]];
          end
          if (m_busy[k] && (m_e[k] == m_t0[k] + 2)) begin
            if (m_own[k] == PORT_I) begin
              di = 1'b1;
              ir = m_rd[k];
            end else begin
              dd = 1'b1;
              dr = m_we[k] ? 32'd0 : m_rd[k];
            end
            m_busy[k] = 1'b0;
          end
          if (m_e[k] >= m_free[k]) begin
            if (i_req[k] || d_req[k]) begin
              if (k == 0) win = (i_req[k] && d_req[k]) ? !m_lw[k] : d_req[k];
              else if (i_req[k] && m_stall[k] == MAX_STALL) win = PORT_I;
              else win = d_req[k];
              if (!i_req[k] || win == PORT_I) m_stall[k] = 0;
              else if (m_stall[k] < MAX_STALL) m_stall[k]++;
              m_lw[k]   = win;
              m_own[k]  = win;
              m_we[k]   = (win == PORT_D) && d_we[k];
              m_addr[k] = (win == PORT_D) ? d_addr[k] : i_addr[k];
              m_wd[k]   = d_wdata[k];
              m_busy[k] = 1'b1;
              m_t0[k]   = m_e[k];
              m_free[k] = m_e[k] + NUM_PHASES;
              gi = (win == PORT_I);
              gd = (win == PORT_D);
            end else begin
              m_stall[k] = 0;
            end
          end
          m_e[k]++;
        end
        m_gi[k] = gi;
        m_gd[k] = gd;
        check_vec($sformatf("cycle_dut%0d", k), act, pack(gi, gd, di, dd, cs, oe, we, ir, dr, ad, dn));
      end
    end
  endtask

  task automatic d_access(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int we_cycles);
    bit done_seen = 1'b0;
    rdata     = '0;
    we_cycles = 0;
    @(posedge clk);
    #1;
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = addr;
    d_wdata[k] = wdata;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      if (ram_we[k]) we_cycles++;
      if (d_done[k]) begin
        done_seen = 1'b1;
        rdata     = d_rdata[k];
      end
      if (d_gnt[k]) begin
        @(posedge clk);
        #1;
        d_req[k]   = 1'b0;
        d_addr[k]  = $urandom;
        d_wdata[k] = $urandom;
      end
    end
    check1("d_access_completed", done_seen, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          wec;
    bit          seen;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0;  d_req[k] = 1'b0;  d_we[k] = 1'b0;
      i_addr[k] = '0;   d_addr[k] = '0;   d_wdata[k] = '0;
      ram_dout[k] = '0; g_n[k] = 0;       m_gi[k] = 1'b0;  m_gd[k] = 1'b0;
      for (int i = 0; i < 64; i++) begin
        mem[k][i]      = preload(i);
        m_shadow[k][i] = preload(i);
      end
    end
    fork
      compare_loop();
      mem_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_vec("reset_outputs", dut_vec(k), '0);

    // Init hold-off with I already requesting, then the single I read of 0x4.
    @(posedge clk);
    #1;
    i_req[0]  = 1'b1;
    i_addr[0] = 32'h0000_0004;
    rst_n     = 1'b1;
    for (int c = 1; c <= INIT_CYCLES; c++) begin
      @(negedge clk);
      check1("holdoff_i_gnt", i_gnt[0], 1'b0);
      check1("holdoff_ram_cs", ram_cs[0], 1'b0);
    end
    @(negedge clk);
    check1("holdoff_release_i_gnt", i_gnt[0], 1'b1);
    @(posedge clk);
    #1;
    i_req[0]  = 1'b0;
    i_addr[0] = 32'hFFFF_FFF0;
    @(negedge clk);
    check1("iread_ram_cs", ram_cs[0], 1'b1);
    check1("iread_ram_oe", ram_oe[0], 1'b1);
    check1("iread_ram_we", ram_we[0], 1'b0);
    check32("iread_ram_addr", ram_addr[0], 32'h0000_0004);
    @(negedge clk);
    check1("iread_i_done", i_done[0], 1'b1);
    check32("iread_i_rdata", i_rdata[0], 32'h8C22_0000);

    // D write then read back the same word.
    d_access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, wec);
    check32("dwrite_we_cycles", 32'(wec), 32'd1);
    d_access(0, 1'b0, 32'h0000_0010, 32'h0, rd, wec);
    check32("dread_we_cycles", 32'(wec), 32'd0);
    check32("dread_d_rdata", rd, 32'hDEAD_BEEF);

    // Both ports held continuously on both instances, starting from reset.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_vec("reset_pulse_outputs", dut_vec(k), '0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1;  i_addr[k] = 32'h0000_0020;
      d_req[k] = 1'b1;  d_addr[k] = 32'h0000_0030;  d_we[k] = 1'b0;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if ((i_gnt[k] || d_gnt[k]) && g_n[k] < 8) begin
          g_port[k][g_n[k]] = d_gnt[k] ? 1 : 0;
          g_cyc[k][g_n[k]]  = c;
          g_n[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      check1($sformatf("held_grant_count_dut%0d", k), g_n[k] >= 8, 1'b1);
      for (int j = 0; j < g_n[k]; j++) begin
        check32($sformatf("held_order_dut%0d_g%0d", k, j), 32'(g_port[k][j]), 32'(exp_order[k][j]));
        check32($sformatf("held_cycle_dut%0d_g%0d", k, j), 32'(g_cyc[k][j]),
                32'(INIT_CYCLES + 1 + NUM_PHASES * j));
      end
    end
    repeat (4) @(posedge clk);

    // Reset dropped while the I read is in its command cycle.
    #1;
    i_req[0]  = 1'b1;
    i_addr[0] = 32'h0000_0008;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = i_gnt[0];
    end
    check1("midrst_gnt_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    i_req[0] = 1'b0;
    check1("midrst_in_cmd", ram_cs[0], 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("midrst_async_outputs", dut_vec(0), '0);
    @(posedge clk);
    #1;
    i_req[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= INIT_CYCLES; c++) begin
      @(negedge clk);
      check1("midrst_holdoff_i_gnt", i_gnt[0], 1'b0);
      check1("midrst_no_i_done", i_done[0], 1'b0);
    end
    @(negedge clk);
    check1("midrst_regrant", i_gnt[0], 1'b1);
    @(posedge clk);
    #1;
    i_req[0] = 1'b0;
    repeat (3) @(posedge clk);

    // Random traffic, requests held until granted, with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst_n = !(c % 700 == 699);
      for (int k = 0; k < 2; k++) begin
        if (m_gi[k]) begin
          i_req[k]  = 1'b0;
          i_addr[k] = $urandom;
        end
        if (m_gd[k]) begin
          d_req[k]   = 1'b0;
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
          d_we[k]    = 1'($urandom_range(0, 1));
        end
        if (!i_req[k] && $urandom_range(0, 2) == 0) begin
          i_req[k]  = 1'b1;
          i_addr[k] = $urandom;
        end
        if (!d_req[k] && $urandom_range(0, 2) == 0) begin
          d_req[k]   = 1'b1;
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
        end
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    repeat (6) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
